pe_feed_ctrl: RTL and testbench
===============================

Name: pe_feed_ctrl

Overview:
Hardware initiator for the parallel_pe stream interface. It accepts one dot-product command at a time (SRAM base address and beat count). It reads paired neuron/weight rows from on-chip SRAM and drives the PE with vld_i and ctl first/last flags. It then captures the single PE result and returns it on a valid/ready result port. It sits between the instruction decoder and parallel_pe.

Parameters:
DATA_W, 512, width of one neuron/weight row
ADDR_W, 16, SRAM row address width
LEN_W, 8, beat-count width (0 encodes 2^LEN_W)
RES_W, 32, PE result width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready
cmd_base  in  ADDR_W  first SRAM row
cmd_len  in  LEN_W  beats in this dot product
sram_ren  out  1  read enable, shared by neuron and weight SRAMs
sram_addr  out  ADDR_W  read row address
neuron_rdata  in  DATA_W  neuron row, valid 1 cycle after sram_ren
weight_rdata  in  DATA_W  weight row, valid 1 cycle after sram_ren
pe_neuron  out  DATA_W  to parallel_pe.neuron
pe_weight  out  DATA_W  to parallel_pe.weight
pe_ctl  out  2  [0]=first beat, [1]=last beat
pe_vld_i  out  1  beat valid to PE
pe_result  in  RES_W  PE result
pe_vld_o  in  1  PE result valid (1-cycle pulse)
res_vld  out  1  result valid
res_rdy  in  1  result ready
res_data  out  RES_W  captured result
perf_busy_cyc  out  32  busy-cycle counter (see Optional Feature)

Behaviour:
- Reset values:
  - cmd_rdy=0 during reset; IDLE drives it to 1 after reset is released.
  - sram_ren=0, sram_addr=0, pe_ctl=0, pe_vld_i=0, res_vld=0, res_data=0, perf_busy_cyc=0.
- FSM states:
  - IDLE: cmd_rdy=1. On cmd_vld, latch base and len, clear beat counter cnt, go to ISSUE.
  - ISSUE: each cycle sram_ren=1 and sram_addr=base+cnt, truncated mod 2^ADDR_W (wraps FFFF->0000). cnt increments each cycle. On the cycle cnt==len-1 (len 0 means 256), go to WAIT.
  - WAIT: hold until pe_vld_o=1, capture pe_result into res_data, go to OUT. No timeout.
  - OUT: res_vld=1, held with stable res_data until res_rdy=1, then return to IDLE.
- cmd_rdy is asserted only in IDLE; the block accepts no new command while a result is pending.
- PE beat generation (registered from the ISSUE-cycle signals):
  - pe_vld_i = sram_ren delayed 1 cycle.
  - pe_ctl[0] = (cnt==0) delayed 1 cycle.
  - pe_ctl[1] = (cnt==len-1) delayed 1 cycle.
  - pe_neuron and pe_weight pass through neuron_rdata and weight_rdata combinationally, so data and flags align.
  - For len=1, the single beat carries pe_ctl=2'b11.
  - pe_ctl is 0 whenever pe_vld_i=0.
- Latency: command accepted at edge T; first sram_ren in cycle T+1; first pe_vld_i in cycle T+2. Beats are back-to-back with no bubbles.
- pe_vld_o outside WAIT (including during ISSUE) is ignored and res_data is unchanged.
- Simultaneous OUT handshake and new cmd_vld: the command is not accepted that cycle; it is taken in the following IDLE cycle.
- Reset asserted mid-operation: all state clears immediately (async). pe_vld_i drops without a last beat. The PE is reset by the same rst_n.

Optional Feature:
PE_FEED_PERF_EN
- Defined: perf_busy_cyc increments every cycle the FSM is not IDLE, saturating at 32'hFFFF_FFFF and cleared only by reset.
- Undefined: perf_busy_cyc is tied to 0 and no counter flops are synthesised.

Decomposition:
- Package pe_feed_pkg holds:
  - FSM state enum (IDLE, ISSUE, WAIT, OUT);
  - CTL_FIRST=0 and CTL_LAST=1 bit indices;
  - default width constants.
- The address/beat generator (base latch, cnt, first/last compare, 1-cycle flag delay) is a natural sub-module: pe_feed_addr_gen.
- The FSM and result register stay in the top module.

Test Plan:
- Basic run:
  - Stimulus: cmd base=0x0000, len=20; PE model returns 0x12345678 5 cycles after the last beat.
  - Expected: addresses 0x00..0x13 in 20 consecutive cycles; pe_ctl[0] only on beat 1 and pe_ctl[1] only on beat 20; res_data=0x12345678 with res_vld.
- len=1 at base 0x0032:
  - Expected: exactly one pe_vld_i beat with pe_ctl=2'b11, then WAIT.
- len=0:
  - Expected: 256 beats, pe_ctl[1] on beat 256; addresses base..base+0xFF.
- Address wrap: base=0xFFFE, len=4:
  - Expected: sram_addr sequence FFFE, FFFF, 0000, 0001.
- Result back-pressure: hold res_rdy=0 for 10 cycles after res_vld, with cmd_vld held high:
  - Expected: res_vld and res_data stable; cmd_rdy=0 throughout.
  - Expected: after res_rdy, the next command is accepted the cycle after OUT exits.
- Reset mid-ISSUE: assert rst_n=0 on beat 7 of a len=20 command.
  - Expected: pe_vld_i, sram_ren and res_vld go to 0 immediately.
  - Expected: after release, cmd_rdy=1 and a fresh command runs correctly.
  - With PE_FEED_PERF_EN defined: perf_busy_cyc=0 after reset.

Source files
------------

// File: rtl/pe_feed_pkg.sv
// Shared types and constants for the parallel_pe feed controller.
package pe_feed_pkg;

   localparam int DATA_W_DEF = 512;
   localparam int ADDR_W_DEF = 16;
   localparam int LEN_W_DEF  = 8;
   localparam int RES_W_DEF  = 32;

   localparam int CTL_FIRST = 0;
   localparam int CTL_LAST  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/pe_feed_addr_gen.sv
// Address/beat generator: latches base and length, walks SRAM rows, and
// produces PE first/last flags delayed one cycle to line up with read data.
module pe_feed_addr_gen
   import pe_feed_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              issue,
   input  logic [ADDR_W-1:0] base_in,
   input  logic [LEN_W-1:0]  len_in,
   output logic              is_last,
   output logic              sram_ren,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              pe_vld_i,
   output logic [1:0]        pe_ctl
);

   logic [ADDR_W-1:0] base;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  cnt;
   logic [LEN_W-1:0]  len_m1;

   // len of 0 wraps to all-ones, giving 2^LEN_W beats
   assign len_m1    = len - LEN_W'(1);
   assign is_last   = (cnt == len_m1);
   assign sram_ren  = issue;
   assign sram_addr = issue ? (base + ADDR_W'(cnt)) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base     <= '0;
         len      <= '0;
         cnt      <= '0;
         pe_vld_i <= 1'b0;
         pe_ctl   <= 2'b00;
      end else begin
         if (start) begin
            base <= base_in;
            len  <= len_in;
            cnt  <= '0;
         end else if (issue) begin
            cnt <= cnt + LEN_W'(1);
         end
         pe_vld_i          <= issue;
         pe_ctl[CTL_FIRST] <= issue && (cnt == '0);
         pe_ctl[CTL_LAST]  <= issue && is_last;
      end
   end

endmodule

// File: rtl/pe_feed_ctrl.sv
// Command-driven feeder for parallel_pe: issues SRAM rows, then returns the
// PE result on a valid/ready port. PE_FEED_PERF_EN adds a busy-cycle counter.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | one SRAM read per cycle, base+cnt
// WAIT  | all beats sent, waiting for pe_vld_o
// OUT   | result held on res_data until res_rdy
module pe_feed_ctrl
   import pe_feed_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int RES_W  = RES_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_vld,
   output logic              cmd_rdy,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              sram_ren,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] neuron_rdata,
   input  logic [DATA_W-1:0] weight_rdata,
   output logic [DATA_W-1:0] pe_neuron,
   output logic [DATA_W-1:0] pe_weight,
   output logic [1:0]        pe_ctl,
   output logic              pe_vld_i,
   input  logic [RES_W-1:0]  pe_result,
   input  logic              pe_vld_o,
   output logic              res_vld,
   input  logic              res_rdy,
   output logic [RES_W-1:0]  res_data,
   output logic [31:0]       perf_busy_cyc
);

   state_t state, state_nxt;
   logic   live;
   logic   start, issue, capture, is_last;

   assign pe_neuron = neuron_rdata;
   assign pe_weight = weight_rdata;

   pe_feed_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .issue     (issue),
      .base_in   (cmd_base),
      .len_in    (cmd_len),
      .is_last   (is_last),
      .sram_ren  (sram_ren),
      .sram_addr (sram_addr),
      .pe_vld_i  (pe_vld_i),
      .pe_ctl    (pe_ctl)
   );

   // live keeps cmd_rdy low while reset is held, rising one edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         live     <= 1'b0;
         res_data <= '0;
      end else begin
         state <= state_nxt;
         live  <= 1'b1;
         if (capture) res_data <= pe_result;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_rdy   = 1'b0;
      res_vld   = 1'b0;
      start     = 1'b0;
      issue     = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            cmd_rdy = live;
            if (live && cmd_vld) begin
               start     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (is_last) state_nxt = WAIT;
         end
         WAIT: begin
            if (pe_vld_o) begin
               capture   = 1'b1;
               state_nxt = OUT;
            end
         end
         OUT: begin
            res_vld = 1'b1;
            if (res_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef PE_FEED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cyc <= '0;
      end else if (state != IDLE && perf_busy_cyc != 32'hFFFF_FFFF) begin
         perf_busy_cyc <= perf_busy_cyc + 32'd1;
      end
   end
`else
   assign perf_busy_cyc = '0;
`endif

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Directed and randomized bench for pe_feed_ctrl with SRAM and PE models.
module tb_pe_feed_ctrl;

   localparam int DW = 512;
   localparam int AW = 16;
   localparam int LW = 8;
   localparam int RW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_vld = 1'b0;
   logic          cmd_rdy;
   logic [AW-1:0] cmd_base = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          sram_ren;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] neuron_rdata = '0;
   logic [DW-1:0] weight_rdata = '0;
   logic [DW-1:0] pe_neuron;
   logic [DW-1:0] pe_weight;
   logic [1:0]    pe_ctl;
   logic          pe_vld_i;
   logic [RW-1:0] pe_result = '0;
   logic          pe_vld_o = 1'b0;
   logic          res_vld;
   logic          res_rdy = 1'b0;
   logic [RW-1:0] res_data;
   logic [31:0]   perf_busy_cyc;

   int            checks = 0;
   int            errors = 0;
   logic [RW-1:0] prev_res = '0;

   pe_feed_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_vld       (cmd_vld),
      .cmd_rdy       (cmd_rdy),
      .cmd_base      (cmd_base),
      .cmd_len       (cmd_len),
      .sram_ren      (sram_ren),
      .sram_addr     (sram_addr),
      .neuron_rdata  (neuron_rdata),
      .weight_rdata  (weight_rdata),
      .pe_neuron     (pe_neuron),
      .pe_weight     (pe_weight),
      .pe_ctl        (pe_ctl),
      .pe_vld_i      (pe_vld_i),
      .pe_result     (pe_result),
      .pe_vld_o      (pe_vld_o),
      .res_vld       (res_vld),
      .res_rdy       (res_rdy),
      .res_data      (res_data),
      .perf_busy_cyc (perf_busy_cyc)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] npat(input logic [AW-1:0] a);
      return {16{a, ~a}};
   endfunction

   function automatic logic [DW-1:0] wpat(input logic [AW-1:0] a);
      return {32{a ^ 16'hA5C3}};
   endfunction

   // SRAM: row contents are a fixed function of the address, one-cycle latency
   always @(posedge clk) begin
      if (sram_ren) begin
         neuron_rdata <= npat(sram_addr);
         weight_rdata <= wpat(sram_addr);
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge. Returns at the negedge of the first IDLE cycle,
   // or right after asserting reset when rst_at matches an issue cycle.
   task automatic run_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len,
                          input int pe_dly, input logic [RW-1:0] res, input int hold,
                          input bit spur, input bit keep_vld, input int rst_at);
      int n;
      int t;
      int j;
      logic [AW-1:0] a;
      n = (len == 0) ? 256 : int'(len);
      cmd_vld  = 1'b1;
      cmd_base = base;
      cmd_len  = len;
      t = 0;
      while (!cmd_rdy && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("cmd_accept_timeout", t < 50, 1'b1);
      @(negedge clk);
      if (!keep_vld) cmd_vld = 1'b0;
      for (int k = 1; k <= n + 1; k++) begin
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_sram_ren", sram_ren, 1'b0);
            chk("rst_sram_addr", sram_addr, 16'h0);
            chk("rst_pe_vld_i", pe_vld_i, 1'b0);
            chk("rst_pe_ctl", pe_ctl, 2'b00);
            chk("rst_res_vld", res_vld, 1'b0);
            chk("rst_cmd_rdy", cmd_rdy, 1'b0);
            chk("rst_res_data", res_data, 32'h0);
            cmd_vld  = 1'b0;
            pe_vld_o = 1'b0;
            prev_res = '0;
            return;
         end
         a = base + 16'(k - 1);
         j = k - 2;
         chk("sram_ren", sram_ren, k <= n);
         chk("sram_addr", sram_addr, (k <= n) ? a : 16'h0);
         chk("pe_vld_i", pe_vld_i, k >= 2);
         chk("pe_ctl", pe_ctl, (k >= 2) ? {j == n - 1, j == 0} : 2'b00);
         if (k >= 2) begin
            chk("pe_neuron", pe_neuron, npat(base + 16'(j)));
            chk("pe_weight", pe_weight, wpat(base + 16'(j)));
         end
         chk("cmd_rdy_busy", cmd_rdy, 1'b0);
         if (spur && k == 1) begin
            pe_vld_o  = 1'b1;
            pe_result = 32'hDEAD_BEEF;
         end else begin
            pe_vld_o = 1'b0;
         end
         @(negedge clk);
      end
      pe_vld_o = 1'b0;
      for (int d = 0; d < pe_dly; d++) begin
         chk("wait_pe_vld_i", pe_vld_i, 1'b0);
         chk("wait_sram_ren", sram_ren, 1'b0);
         chk("wait_res_vld", res_vld, 1'b0);
         chk("wait_res_data", res_data, prev_res);
         pe_result = $urandom;
         @(negedge clk);
      end
      pe_vld_o  = 1'b1;
      pe_result = res;
      @(negedge clk);
      pe_vld_o  = 1'b0;
      pe_result = $urandom;
      for (int h = 0; h <= hold; h++) begin
         chk("out_res_vld", res_vld, 1'b1);
         chk("out_res_data", res_data, res);
         chk("out_cmd_rdy", cmd_rdy, 1'b0);
         res_rdy = (h == hold);
         @(negedge clk);
      end
      res_rdy = 1'b0;
      chk("idle_res_vld", res_vld, 1'b0);
      chk("idle_cmd_rdy", cmd_rdy, 1'b1);
      chk("idle_res_data", res_data, res);
      prev_res = res;
   endtask

   initial begin
      logic [AW-1:0] rb;
      logic [LW-1:0] rl;
      repeat (2) @(negedge clk);
      chk("reset_cmd_rdy", cmd_rdy, 1'b0);
      chk("reset_sram_ren", sram_ren, 1'b0);
      chk("reset_sram_addr", sram_addr, 16'h0);
      chk("reset_pe_ctl", pe_ctl, 2'b00);
      chk("reset_pe_vld_i", pe_vld_i, 1'b0);
      chk("reset_res_vld", res_vld, 1'b0);
      chk("reset_res_data", res_data, 32'h0);
      chk("reset_perf", perf_busy_cyc, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_cmd_rdy", cmd_rdy, 1'b1);

      run_cmd(16'h0000, 8'd20, 4, 32'h1234_5678, 0, 1'b0, 1'b0, 0);
      run_cmd(16'h0032, 8'd1, 2, $urandom, 1, 1'b0, 1'b0, 0);
      run_cmd(16'h1200, 8'd0, 3, $urandom, 0, 1'b0, 1'b0, 0);
      run_cmd(16'hFFFE, 8'd4, 1, $urandom, 0, 1'b1, 1'b0, 0);
      run_cmd(16'h0400, 8'd5, 2, 32'hCAFE_F00D, 10, 1'b0, 1'b1, 0);
      run_cmd(16'h0777, 8'd3, 0, $urandom, 0, 1'b0, 1'b0, 0);

      run_cmd(16'h2000, 8'd20, 0, 32'h0, 0, 1'b0, 1'b0, 7);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_cmd_rdy", cmd_rdy, 1'b1);
      chk("rst_release_res_data", res_data, 32'h0);
`ifdef PE_FEED_PERF_EN
      chk("rst_release_perf", perf_busy_cyc, 32'h0);
`endif
      run_cmd(16'h3000, 8'd20, 5, $urandom, 2, 1'b0, 1'b0, 0);

      for (int r = 0; r < 10; r++) begin
         rb = 16'($urandom);
         rl = 8'($urandom_range(1, 12));
         run_cmd(rb, rl, $urandom_range(0, 6), $urandom, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'b0, 0);
      end
`ifndef PE_FEED_PERF_EN
      chk("perf_tied_off", perf_busy_cyc, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
